// File: rtl/sm_led_slot_indicator_if.sv
// rtl/sm_led_slot_indicator_if.sv - sensor/node inputs and RGB slot outputs of the LED slot indicator
interface sm_led_slot_indicator_if #(
  parameter int N_LED  = 3,
  parameter int NODE_W = 6
);
  localparam int SC_W = $clog2(N_LED + 1);

  logic              red;
  logic              green;
  logic              blue;
  logic [NODE_W-1:0] node;
  logic              blink_en;
  logic [N_LED-1:0]  led_r;
  logic [N_LED-1:0]  led_g;
  logic [N_LED-1:0]  led_b;
  logic [SC_W-1:0]   slot_cnt;
  logic              full;

  modport master (
    output red, green, blue, node, blink_en,
    input  led_r, led_g, led_b, slot_cnt, full
  );

  modport slave (
    input  red, green, blue, node, blink_en,
    output led_r, led_g, led_b, slot_cnt, full
  );
endinterface

// File: rtl/sm_led_slot_indicator.sv
// rtl/sm_led_slot_indicator.sv - debounced colour capture into RGB LED slots with clear and blink
module sm_led_slot_indicator #(
  parameter int N_LED      = 3,
  parameter int NODE_W     = 6,
  parameter int CLR_NODE_A = 11,
  parameter int CLR_NODE_B = 22,
  parameter int DEBOUNCE   = 4,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                  clk_50,
  input  logic                  rst_n,
  sm_led_slot_indicator_if.slave io
);
  localparam int SC_W  = $clog2(N_LED + 1);
  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam int BLK_W = $clog2(BLINK_DIV);

  typedef enum logic [1:0] {IDLE, QUAL, LATCHED} state_t;

  // Sampled sensor lines, packed {r,g,b}
  logic [2:0] samp_q;
  logic       samp_none;
  logic       samp_valid;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       col_q, col_d;
  logic             cap;

  logic [N_LED-1:0][2:0] slot_q, slot_d;
  logic [SC_W-1:0]       slot_cnt_q, slot_cnt_d;
  logic                  full_q;
  logic                  clr;

  logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
  logic             phase_q, phase_d;

  logic [N_LED-1:0] led_r_q, led_r_d;
  logic [N_LED-1:0] led_g_q, led_g_d;
  logic [N_LED-1:0] led_b_q, led_b_d;

  assign samp_none  = (samp_q == 3'b000);
  assign samp_valid = (samp_q == 3'b100) || (samp_q == 3'b010) || (samp_q == 3'b001);
  assign clr        = (io.node == NODE_W'(CLR_NODE_A)) || (io.node == NODE_W'(CLR_NODE_B));

  // Register the raw sensor lines once before qualification
  always_ff @(posedge clk_50) begin
    if (!rst_n) samp_q <= 3'b000;
    else        samp_q <= {io.red, io.green, io.blue};
  end

  // Qualifier state register
  always_ff @(posedge clk_50) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      col_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
    end
  end

  // Qualifier next state: count a run of one identical one-hot colour
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    case (state_q)
      IDLE: begin
        if (samp_valid) begin
          col_d = samp_q;
          if (DEBOUNCE == 1) begin
            state_d = LATCHED;
          end else begin
            state_d = QUAL;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      QUAL: begin
        if (samp_q == col_q) begin
          if (cnt_q == CNT_W'(DEBOUNCE - 1)) state_d = LATCHED;
          else                               cnt_d   = cnt_q + CNT_W'(1);
        end else if (samp_valid) begin
          col_d = samp_q;
          cnt_d = CNT_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
      LATCHED: begin
        // Only a clean "no colour" sample releases; invalid mixes keep the latch
        if (samp_none) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Qualifier output: one-cycle capture pulse when the run completes
  always_comb begin
    cap = 1'b0;
    case (state_q)
      IDLE:    cap = samp_valid && (DEBOUNCE == 1);
      QUAL:    cap = (samp_q == col_q) && (cnt_q == CNT_W'(DEBOUNCE - 1));
      default: cap = 1'b0;
    endcase
  end

  // Slot fill and clear; clear overrides a capture in the same cycle
  always_comb begin
    slot_d     = slot_q;
    slot_cnt_d = slot_cnt_q;
    if (clr) begin
      slot_d     = '0;
      slot_cnt_d = '0;
    end else if (cap && (slot_cnt_q != SC_W'(N_LED))) begin
      for (int i = 0; i < N_LED; i++) begin
        if (slot_cnt_q == SC_W'(i)) slot_d[i] = samp_q;
      end
      slot_cnt_d = slot_cnt_q + SC_W'(1);
    end
  end

  // Blink timebase: phase toggles each BLINK_DIV cycles, parked "on" when disabled
  always_comb begin
    blk_cnt_d = blk_cnt_q;
    phase_d   = phase_q;
    if (!io.blink_en) begin
      blk_cnt_d = '0;
      phase_d   = 1'b1;
    end else if (blk_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
      blk_cnt_d = '0;
      phase_d   = ~phase_q;
    end else begin
      blk_cnt_d = blk_cnt_q + BLK_W'(1);
    end
  end

  // LED drive from next slot contents gated by next blink phase
  always_comb begin
    led_r_d = '0;
    led_g_d = '0;
    led_b_d = '0;
    for (int i = 0; i < N_LED; i++) begin
      led_r_d[i] = slot_d[i][2] & phase_d;
      led_g_d[i] = slot_d[i][1] & phase_d;
      led_b_d[i] = slot_d[i][0] & phase_d;
    end
  end

  // Slot, blink and output registers
  always_ff @(posedge clk_50) begin
    if (!rst_n) begin
      slot_q     <= '0;
      slot_cnt_q <= '0;
      full_q     <= 1'b0;
      blk_cnt_q  <= '0;
      phase_q    <= 1'b1;
      led_r_q    <= '0;
      led_g_q    <= '0;
      led_b_q    <= '0;
    end else begin
      slot_q     <= slot_d;
      slot_cnt_q <= slot_cnt_d;
      full_q     <= (slot_cnt_d == SC_W'(N_LED));
      blk_cnt_q  <= blk_cnt_d;
      phase_q    <= phase_d;
      led_r_q    <= led_r_d;
      led_g_q    <= led_g_d;
      led_b_q    <= led_b_d;
    end
  end

  assign io.led_r    = led_r_q;
  assign io.led_g    = led_g_q;
  assign io.led_b    = led_b_q;
  assign io.slot_cnt = slot_cnt_q;
  assign io.full     = full_q;
endmodule
